// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider (DIV/DIVU), result = {remainder, quotient}
// Optional divide-by-zero flag output: define DIV_ZERO_FLAG_EN.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sign,
    input  logic               annul,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               busy,
    output logic               div_zero
);

    typedef enum logic [1:0] {IDLE, DIV_ON, DZERO, DEND} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   step_rem;
    logic [WIDTH-1:0]   step_quo;

    // quo_q starts as the dividend magnitude and fills with quotient bits from the right
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        diff     = shifted - {1'b0, dvs_q};
        step_rem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        step_quo = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start && !annul) begin
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = (sign && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
                    dvs_d   = (sign && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
                    negq_d  = sign && (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                    negr_d  = sign && opdata1[WIDTH-1];
                    state_d = (opdata2 == '0) ? DZERO : DIV_ON;
                end
            end
            DIV_ON: begin
                if (annul) begin
                    state_d = IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + CNT_W'(1);
                    // final step lands directly in DEND with the sign-corrected result
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = DEND;
                        result_d = {negr_q ? -step_rem : step_rem,
                                    negq_q ? -step_quo : step_quo};
                    end
                end
            end
            DZERO: begin
                if (annul) begin
                    state_d = IDLE;
                end else begin
                    state_d  = DEND;
                    result_d = '0;
                end
            end
            DEND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
        end
    end

`ifdef DIV_ZERO_FLAG_EN
    logic dz_q;

    // sticky until the next accepted start so it can be read alongside or after ready
    always_ff @(posedge clk) begin
        if (rst) begin
            dz_q <= 1'b0;
        end else if (state_q == IDLE && start && !annul) begin
            dz_q <= 1'b0;
        end else if (state_q == DZERO && !annul) begin
            dz_q <= 1'b1;
        end
    end

    assign div_zero = dz_q;
`else
    assign div_zero = 1'b0;
`endif

    assign result = result_q;
    assign ready  = (state_q == DEND);
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit with an arithmetic reference model
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sign = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] opdata1 = '0;
    logic [31:0] opdata2 = '0;
    logic [63:0] result;
    logic        ready;
    logic        busy;
    logic        div_zero;

`ifdef DIV_ZERO_FLAG_EN
    localparam bit FLAG = 1'b1;
`else
    localparam bit FLAG = 1'b0;
`endif

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .sign(sign), .annul(annul),
        .opdata1(opdata1), .opdata2(opdata2),
        .result(result), .ready(ready), .busy(busy), .div_zero(div_zero)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Model: operation occupies intervals [m_s, m_e] after the edges of those numbers
    int          m_s = -1;
    int          m_e = -1;
    int          rst_edge = -1;
    bit          m_rdy_on = 1'b0;
    bit          check_en = 1'b0;
    logic [63:0] pend = '0;
    logic [63:0] cur_res = '0;
    bit          pend_dz = 1'b0;
    bit          cur_dz = 1'b0;
    bit          e_busy;
    bit          e_rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            if (cyc == rst_edge) begin
                cur_res = '0;
                cur_dz  = 1'b0;
            end
            e_busy = (m_s >= 0) && (cyc >= m_s) && (cyc <= m_e);
            e_rdy  = e_busy && m_rdy_on && (cyc == m_e);
            if (e_busy && cyc == m_s) cur_dz = 1'b0;
            if (e_rdy) begin
                cur_res = pend;
                cur_dz  = pend_dz;
            end
            chk("busy", 64'(busy), 64'(e_busy));
            chk("ready", 64'(ready), 64'(e_rdy));
            chk("result", result, cur_res);
            chk("div_zero", 64'(div_zero), 64'(FLAG & cur_dz));
        end
    end

    task automatic issue_start(input bit s, input logic [31:0] a, input logic [31:0] b,
                               input bit with_annul, input bit annul_next, output bit acc);
        @(posedge clk); #1;
        start   = 1'b1;
        sign    = s;
        opdata1 = a;
        opdata2 = b;
        annul   = with_annul;
        acc = !with_annul && !((m_s >= 0) && (cyc >= m_s) && (cyc <= m_e));
        if (acc) begin
            m_s      = cyc + 1;
            m_e      = m_s + ((b == 32'd0) ? 1 : 32);
            m_rdy_on = 1'b1;
            pend     = model_div(s, a, b);
            pend_dz  = (b == 32'd0);
        end
        @(posedge clk); #1;
        start   = 1'b0;
        sign    = ~s;
        opdata1 = $urandom;
        opdata2 = $urandom;
        annul   = annul_next;
        if (annul_next) begin
            if ((m_s >= 0) && (cyc >= m_s) && (cyc < m_e)) begin
                m_e      = cyc;
                m_rdy_on = 1'b0;
            end
            @(posedge clk); #1;
            annul = 1'b0;
        end
    endtask

    task automatic do_annul();
        @(posedge clk); #1;
        annul = 1'b1;
        if ((m_s >= 0) && (cyc >= m_s) && (cyc < m_e)) begin
            m_e      = cyc;
            m_rdy_on = 1'b0;
        end
        @(posedge clk); #1;
        annul = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst      = 1'b1;
        rst_edge = cyc + 1;
        if ((m_s >= 0) && (cyc >= m_s) && (cyc < m_e)) begin
            m_e      = cyc;
            m_rdy_on = 1'b0;
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_until(input int target);
        for (int i = 0; i < 100 && cyc < target; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_ready(input int s0, input int exp_lat, input bit use_lit,
                              input logic [63:0] lit, input string tag);
        bit got = 1'b0;
        int at = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                got = 1'b1;
                at  = cyc;
            end
        end
        chk({tag, "_ready_seen"}, 64'(got), 64'd1);
        if (got) begin
            chk({tag, "_latency"}, 64'(at - s0), 64'(exp_lat));
            if (use_lit) chk({tag, "_result"}, result, lit);
        end
    endtask

    task automatic run(input bit s, input logic [31:0] a, input logic [31:0] b,
                       input int exp_lat, input bit use_lit, input logic [63:0] lit, input string tag);
        bit acc;
        issue_start(s, a, b, 1'b0, 1'b0, acc);
        chk({tag, "_accepted"}, 64'(acc), 64'd1);
        wait_ready(m_s, exp_lat, use_lit, lit, tag);
    endtask

    initial begin
        bit acc;
        int s0;

        chk("model_udiv", model_div(1'b0, 32'd7, 32'd2), 64'h00000001_00000003);
        chk("model_sdiv", model_div(1'b1, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
        chk("model_ovf", model_div(1'b1, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
        chk("model_100_7", model_div(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_result", result, 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_div_zero", 64'(div_zero), 64'd0);
        check_en = 1'b1;

        run(1'b0, 32'd7, 32'd2, 32, 1'b1, 64'h00000001_00000003, "u7_2");
        run(1'b1, 32'hFFFFFFF9, 32'd2, 32, 1'b1, 64'hFFFFFFFF_FFFFFFFD, "sm7_2");
        run(1'b1, 32'd7, 32'hFFFFFFFE, 32, 1'b1, 64'h00000001_FFFFFFFD, "s7_m2");
        run(1'b1, 32'h80000000, 32'hFFFFFFFF, 32, 1'b1, 64'h00000000_80000000, "s_ovf");
        run(1'b0, 32'h80000000, 32'hFFFFFFFF, 32, 1'b1, 64'h80000000_00000000, "u_ovf");
        run(1'b0, 32'd5, 32'd0, 1, 1'b1, 64'd0, "dz");
        chk("dz_flag", 64'(div_zero), 64'(FLAG));

        issue_start(1'b0, 32'd1000, 32'd3, 1'b0, 1'b0, acc);
        s0 = m_s;
        wait_until(s0 + 9);
        do_annul();
        chk("annul_busy", 64'(busy), 64'd0);
        chk("annul_result", result, 64'd0);
        run(1'b0, 32'd100, 32'd7, 32, 1'b1, 64'h00000002_0000000E, "after_annul");

        issue_start(1'b0, 32'd5, 32'd0, 1'b0, 1'b1, acc);
        repeat (3) @(posedge clk);
        #1;
        chk("dz_annul_busy", 64'(busy), 64'd0);
        chk("dz_annul_result", result, 64'h00000002_0000000E);

        issue_start(1'b0, 32'd10, 32'd3, 1'b1, 1'b0, acc);
        repeat (2) @(posedge clk);
        #1;
        chk("start_annul_busy", 64'(busy), 64'd0);

        issue_start(1'b0, 32'd200, 32'd9, 1'b0, 1'b0, acc);
        s0 = m_s;
        wait_until(s0 + 5);
        issue_start(1'b0, 32'd50, 32'd5, 1'b0, 1'b0, acc);
        wait_ready(s0, 32, 1'b1, 64'h00000002_00000016, "busy_ignore");
        repeat (40) @(posedge clk);

        issue_start(1'b0, 32'd9, 32'd3, 1'b0, 1'b0, acc);
        wait_until(m_e - 1);
        do_annul();
        chk("dend_annul_result", result, 64'h00000000_00000003);

        issue_start(1'b0, 32'd12345, 32'd67, 1'b0, 1'b0, acc);
        wait_until(m_s + 19);
        do_reset();
        chk("midrst_result", result, 64'd0);
        chk("midrst_ready", 64'(ready), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_div_zero", 64'(div_zero), 64'd0);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i % 2 == 0) ? $urandom_range(1, 20) : $urandom;
            if (b == 32'd0) b = 32'd1;
            run(i % 3 != 0, a, b, 32, 1'b0, 64'd0, "rand");
        end

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
